// File: rtl/fetch_stage_pipe.sv
// fetch_stage_pipe: MIPS instruction-fetch stage with PC register, next-PC select and IF/ID register.
// Rev 1.0 -- initial release.
`default_nettype none

module fetch_stage_pipe #(
  parameter logic [31:0] RESET_VEC  = 32'h0000_3000,
  parameter logic [31:0] EXC_VEC    = 32'h0000_4180,
  parameter logic [31:0] IMEM_BASE  = 32'h0000_3000,
  parameter int unsigned IMEM_WORDS = 4096,
  parameter bit          DELAY_SLOT = 1'b1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [1:0]  JSel,
  input  logic [31:0] JrTarget,
  input  logic        ExcReq,
  input  logic        EretReq,
  input  logic [31:0] EPC,
  output logic [31:0] IMemAddr,
  input  logic [31:0] IMemRdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PC4D,
  output logic        ValidD,
  output logic        ExcD,
  output logic [4:0]  ExcCodeD
);

  localparam logic [32:0] c_imem_end  = {1'b0, IMEM_BASE} + (33'(IMEM_WORDS) * 33'd4);
  localparam logic [4:0]  c_exc_adel  = 5'd4;

  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_pcd;
  logic [31:0] r_pc4d;
  logic        r_valid;
  logic        r_exc;
  logic [4:0]  r_exccode;

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic        w_id_ok;
  logic        w_redirect;
  logic [31:0] w_tgt;
  logic        w_fault;
  logic [31:0] w_pc_next;

  assign w_pc4    = r_pc + 32'd4;
  assign w_br_off = {{14{r_instr[15]}}, r_instr[15:0], 2'b00};
  assign w_br_tgt = r_pc4d + w_br_off;
  assign w_j_tgt  = {r_pc4d[31:28], r_instr[25:0], 2'b00};

  // A bubble or a faulted fetch in IF/ID must never steer the PC.
  assign w_id_ok  = r_valid & ~r_exc;

  always_comb begin
    w_redirect = 1'b0;
    w_tgt      = w_br_tgt;
    case (JSel)
      2'b01: begin
        w_redirect = w_id_ok;
        w_tgt      = w_j_tgt;
      end
      2'b10: begin
        w_redirect = w_id_ok;
        w_tgt      = JrTarget;
      end
      default: begin
        w_redirect = w_id_ok & BranchTaken;
        w_tgt      = w_br_tgt;
      end
    endcase
  end

  assign w_fault = (r_pc[1:0] != 2'b00) | (r_pc < IMEM_BASE) | ({1'b0, r_pc} >= c_imem_end);

  always_comb begin
    w_pc_next = w_pc4;
    if (ExcReq)
      w_pc_next = EXC_VEC;
    else if (EretReq)
      w_pc_next = EPC;
    else if (Stall)
      w_pc_next = r_pc;
    else if (w_redirect)
      w_pc_next = w_tgt;
  end

  always_ff @(posedge Clk) begin
    if (Reset)
      r_pc <= RESET_VEC;
    else
      r_pc <= w_pc_next;
  end

  // Bubbles keep the current PC so a later exception still has a meaningful EPC.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_instr   <= 32'd0;
      r_pcd     <= 32'd0;
      r_pc4d    <= 32'd0;
      r_valid   <= 1'b0;
      r_exc     <= 1'b0;
      r_exccode <= 5'd0;
    end else if (ExcReq || EretReq || (!Stall && w_redirect && (DELAY_SLOT == 1'b0))) begin
      r_instr   <= 32'd0;
      r_pcd     <= r_pc;
      r_pc4d    <= w_pc4;
      r_valid   <= 1'b0;
      r_exc     <= 1'b0;
      r_exccode <= 5'd0;
    end else if (!Stall) begin
      r_instr   <= w_fault ? 32'd0 : IMemRdata;
      r_pcd     <= r_pc;
      r_pc4d    <= w_pc4;
      r_valid   <= 1'b1;
      r_exc     <= w_fault;
      r_exccode <= w_fault ? c_exc_adel : 5'd0;
    end
  end

  assign IMemAddr = r_pc;
  assign InstrD   = r_instr;
  assign PCD      = r_pcd;
  assign PC4D     = r_pc4d;
  assign ValidD   = r_valid;
  assign ExcD     = r_exc;
  assign ExcCodeD = r_exccode;

endmodule

`default_nettype wire

// File: tb/tb_fetch_stage_pipe.sv
// tb_fetch_stage_pipe: directed checks of fetch_stage_pipe with delay slot on (A) and off (B).
// Rev 1.0 -- initial release.
`default_nettype none

module tb_fetch_stage_pipe;

  logic        Clk = 1'b0;
  logic        Reset, Stall, BranchTaken, ExcReq, EretReq;
  logic [1:0]  JSel;
  logic [31:0] JrTarget, EPC;

  logic [31:0] addrA, rdA, instrA, pcdA, pc4dA;
  logic        validA, excA;
  logic [4:0]  codeA;
  logic [31:0] addrB, rdB, instrB, pcdB, pc4dB;
  logic        validB, excB;
  logic [4:0]  codeB;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  function automatic logic [31:0] imem(input logic [31:0] a);
    case (a)
      32'h0000_3010: imem = 32'h1000_FFFC;
      32'h0000_3020: imem = 32'h0800_0C40;
      32'h0000_4180: imem = 32'h1000_0010;
      default:       imem = {16'h2400, a[15:0]};
    endcase
  endfunction

  assign rdA = imem(addrA);
  assign rdB = imem(addrB);

  fetch_stage_pipe u_dut_a (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken), .JSel(JSel),
    .JrTarget(JrTarget), .ExcReq(ExcReq), .EretReq(EretReq), .EPC(EPC),
    .IMemAddr(addrA), .IMemRdata(rdA), .InstrD(instrA), .PCD(pcdA), .PC4D(pc4dA),
    .ValidD(validA), .ExcD(excA), .ExcCodeD(codeA)
  );

  fetch_stage_pipe #(.DELAY_SLOT(1'b0)) u_dut_b (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .BranchTaken(BranchTaken), .JSel(JSel),
    .JrTarget(JrTarget), .ExcReq(ExcReq), .EretReq(EretReq), .EPC(EPC),
    .IMemAddr(addrB), .IMemRdata(rdB), .InstrD(instrB), .PCD(pcdB), .PC4D(pc4dB),
    .ValidD(validB), .ExcD(excB), .ExcCodeD(codeB)
  );

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    Reset = 1'b1; Stall = 1'b0; BranchTaken = 1'b0; JSel = 2'b00;
    JrTarget = 32'd0; ExcReq = 1'b0; EretReq = 1'b0; EPC = 32'd0;
    step(); step();
    chk("rst_pc_a",    addrA,          32'h0000_3000);
    chk("rst_valid_a", 32'(validA),    32'd0);
    chk("rst_instr_a", instrA,         32'd0);
    chk("rst_pcd_a",   pcdA,           32'd0);
    chk("rst_pc4d_a",  pc4dA,          32'd0);
    chk("rst_exc_a",   {26'd0, excA, codeA}, 32'd0);
    chk("rst_valid_b", 32'(validB),    32'd0);

    Reset = 1'b0;
    #1;
    chk("idle0_pc", addrA, 32'h0000_3000);
    step();
    chk("idle1_pc",    addrA,       32'h0000_3004);
    chk("idle1_valid", 32'(validA), 32'd1);
    chk("idle1_pcd",   pcdA,        32'h0000_3000);
    chk("idle1_instr", instrA,      32'h2400_3000);
    chk("idle1_pc4d",  pc4dA,       32'h0000_3004);
    step();
    chk("idle2_pc",  addrA, 32'h0000_3008);
    chk("idle2_pcd", pcdA,  32'h0000_3004);
    step();
    chk("idle3_pc",  addrA, 32'h0000_300C);
    step(); step();
    chk("beq_in_id_instr", instrA, 32'h1000_FFFC);
    chk("beq_in_id_pc",    addrA,  32'h0000_3014);

    // beq imm -4 words from PC4D 0x3014 -> 0x3004
    BranchTaken = 1'b1;
    step();
    BranchTaken = 1'b0;
    chk("beq_pc_a",      addrA,       32'h0000_3004);
    chk("beq_pc_b",      addrB,       32'h0000_3004);
    chk("slot_pcd_a",    pcdA,        32'h0000_3014);
    chk("slot_valid_a",  32'(validA), 32'd1);
    chk("slot_instr_a",  instrA,      32'h2400_3014);
    chk("squash_valid_b", 32'(validB), 32'd0);
    chk("squash_instr_b", instrB,      32'd0);
    chk("squash_pcd_b",   pcdB,        32'h0000_3014);
    chk("squash_pc4d_b",  pc4dB,       32'h0000_3018);
    step();
    chk("post_beq_pc", addrA, 32'h0000_3008);
    chk("post_beq_pcd", pcdA, 32'h0000_3004);

    for (int i = 0; i < 7; i++) step();
    chk("j_in_id_instr", instrA, 32'h0800_0C40);
    chk("j_in_id_pcd",   pcdA,   32'h0000_3020);
    JSel = 2'b01;
    step();
    JSel = 2'b00;
    chk("j_pc",       addrA,       32'h0000_3100);
    chk("j_slot_pcd", pcdA,        32'h0000_3024);
    chk("j_squash_b", 32'(validB), 32'd0);

    JSel = 2'b10; JrTarget = 32'h0000_3002;
    step();
    JSel = 2'b00;
    chk("jr_pc", addrA, 32'h0000_3002);
    step();
    chk("fault_pcd",   pcdA,        32'h0000_3002);
    chk("fault_exc",   32'(excA),   32'd1);
    chk("fault_code",  32'(codeA),  32'd4);
    chk("fault_instr", instrA,      32'd0);
    chk("fault_valid", 32'(validA), 32'd1);
    chk("fault_pc",    addrA,       32'h0000_3006);

    BranchTaken = 1'b1;
    step();
    BranchTaken = 1'b0;
    chk("fault_no_redirect", addrA, 32'h0000_300A);

    ExcReq = 1'b1;
    step();
    ExcReq = 1'b0;
    chk("exc_pc",    addrA,       32'h0000_4180);
    chk("exc_valid", 32'(validA), 32'd0);
    chk("exc_pcd",   pcdA,        32'h0000_300A);
    chk("exc_exc",   32'(excA),   32'd0);
    step();
    chk("handler_instr", instrA, 32'h1000_0010);

    Stall = 1'b1; BranchTaken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_pc",    addrA,  32'h0000_4184);
      chk("stall_pcd",   pcdA,   32'h0000_4180);
      chk("stall_instr", instrA, 32'h1000_0010);
    end
    Stall = 1'b0;
    step();
    BranchTaken = 1'b0;
    chk("stall_release_pc",  addrA,       32'h0000_41C4);
    chk("stall_release_pcd", pcdA,        32'h0000_4184);
    chk("stall_release_vld", 32'(validA), 32'd1);

    Stall = 1'b1; ExcReq = 1'b1; EretReq = 1'b1; EPC = 32'h0000_3040;
    step();
    ExcReq = 1'b0;
    chk("exc_eret_pc",    addrA,       32'h0000_4180);
    chk("exc_eret_valid", 32'(validA), 32'd0);
    chk("exc_eret_pcd",   pcdA,        32'h0000_41C4);
    step();
    EretReq = 1'b0; Stall = 1'b0;
    chk("eret_pc",    addrA,       32'h0000_3040);
    chk("eret_valid", 32'(validA), 32'd0);
    step();
    chk("eret_fetch_pc",    addrA,  32'h0000_3044);
    chk("eret_fetch_instr", instrA, 32'h2400_3040);

    JSel = 2'b10; JrTarget = 32'h0000_6FF8;
    step();
    JSel = 2'b00;
    chk("top_jr_pc", addrA, 32'h0000_6FF8);
    step(); step();
    chk("top_last_pcd", pcdA,      32'h0000_6FFC);
    chk("top_last_exc", 32'(excA), 32'd0);
    step();
    chk("top_over_pcd",   pcdA,       32'h0000_7000);
    chk("top_over_exc",   32'(excA),  32'd1);
    chk("top_over_code",  32'(codeA), 32'd4);
    chk("top_over_instr", instrA,     32'd0);
    chk("top_over_pc",    addrA,      32'h0000_7004);

    EretReq = 1'b1; EPC = 32'h0000_2FFC;
    step();
    EretReq = 1'b0;
    step();
    chk("below_pcd", pcdA,      32'h0000_2FFC);
    chk("below_exc", 32'(excA), 32'd1);

    EretReq = 1'b1; EPC = 32'hFFFF_FFFC;
    step();
    EretReq = 1'b0;
    step();
    chk("wrap_pc",   addrA,     32'h0000_0000);
    chk("wrap_pc4d", pc4dA,     32'h0000_0000);
    chk("wrap_exc",  32'(excA), 32'd1);

    Reset = 1'b1; ExcReq = 1'b1;
    step();
    Reset = 1'b0; ExcReq = 1'b0;
    chk("midrst_pc",    addrA,       32'h0000_3000);
    chk("midrst_valid", 32'(validA), 32'd0);
    chk("midrst_pcd",   pcdA,        32'd0);
    chk("midrst_exc",   32'(excA),   32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
